// File: rtl/prio_scan_unit.sv
// Purpose : registered merge / find-first-set / ascending-or-descending bit scan.
// Latency : accept at edge N -> beat 0 valid after edge N; scans emit 1 beat/cycle.
// Backpr. : out_ready_i low holds the current beat stable; no accept while a beat is held.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid_i/in_ready_o, in_mode_i, in_a_i, in_b_i, in_mask_i   command side
//   abort_i           synchronous drop of the current command (highest priority)
//   out_valid_o/out_ready_i, out_data_o, out_idx_o, out_cnt_o, out_zero_o, out_last_o
module prio_scan_unit #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [1:0]    in_mode_i,
  input  logic [W-1:0]  in_a_i,
  input  logic [W-1:0]  in_b_i,
  input  logic [W-1:0]  in_mask_i,
  input  logic          abort_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_data_o,
  output logic [IW-1:0] out_idx_o,
  output logic [IW:0]   out_cnt_o,
  output logic          out_zero_o,
  output logic          out_last_o
);

  typedef enum logic {S_IDLE, S_BEAT} state_t;

  localparam logic [1:0]  M_MERGE = 2'd0;
  localparam logic [1:0]  M_FIRST = 2'd1;
  localparam logic [1:0]  M_DN    = 2'd3;
  localparam logic [IW:0] CNT_ONE = (IW+1)'(1);

  state_t        state_q, state_d;
  logic [W-1:0]  pending_q, pending_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic          last_q, last_d;

  // The bit picker is shared between the first beat (fed from the input
  // operand) and the following scan beats (fed from the pending register).
  logic [W-1:0]  src;
  logic [1:0]    sel_mode;
  logic [IW-1:0] lo_idx, hi_idx, pick_idx;
  logic [W-1:0]  pick_bit, rest;

  assign src      = (state_q == S_IDLE) ? in_a_i : pending_q;
  assign sel_mode = (state_q == S_IDLE) ? in_mode_i : mode_q;

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    // Downward loop: the last hit written is the lowest set bit.
    for (int i = W - 1; i >= 0; i--) begin
      if (src[i]) lo_idx = IW'(i);
    end
    // Upward loop: the last hit written is the highest set bit.
    for (int i = 0; i < W; i++) begin
      if (src[i]) hi_idx = IW'(i);
    end
  end

  assign pick_idx = (sel_mode == M_DN) ? hi_idx : lo_idx;
  assign pick_bit = (src == '0) ? '0 : (W'(1) << pick_idx);
  assign rest     = src & ~pick_bit;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    data_d    = data_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    last_d    = last_q;

    if (abort_i) begin
      state_d   = S_IDLE;
      pending_d = '0;
      data_d    = '0;
      idx_d     = '0;
      cnt_d     = '0;
      zero_d    = 1'b0;
      last_d    = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (in_valid_i) begin
        state_d = S_BEAT;
        mode_d  = in_mode_i;
        cnt_d   = '0;
        if (in_mode_i == M_MERGE) begin
          data_d    = (in_a_i & in_mask_i) | (in_b_i & ~in_mask_i);
          idx_d     = '0;
          zero_d    = 1'b0;
          last_d    = 1'b1;
          pending_d = '0;
        end else if (in_a_i == '0) begin
          data_d    = '0;
          idx_d     = '0;
          zero_d    = 1'b1;
          last_d    = 1'b1;
          pending_d = '0;
        end else begin
          data_d = pick_bit;
          idx_d  = pick_idx;
          zero_d = 1'b0;
          if (in_mode_i == M_FIRST) begin
            pending_d = '0;
            last_d    = 1'b1;
          end else begin
            pending_d = rest;
            last_d    = (rest == '0);
          end
        end
      end
    end else if (out_ready_i) begin
      if (last_q) begin
        state_d = S_IDLE;
      end else begin
        // Only scans reach here, and pending is non-zero whenever last is 0.
        data_d    = pick_bit;
        idx_d     = pick_idx;
        zero_d    = 1'b0;
        pending_d = rest;
        last_d    = (rest == '0);
        cnt_d     = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      mode_q    <= M_MERGE;
      data_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      last_q    <= last_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_BEAT);
  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;
  assign out_cnt_o   = cnt_q;
  assign out_zero_o  = zero_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_prio_scan_unit.sv
// Purpose : self-checking bench for prio_scan_unit against a list-of-beats model.
// Latency : checks beat 0 right after the accept edge, then one beat per consumed cycle.
// Backpr. : drives out_ready always-high, in a 1,0,0,1 pattern, or randomly.
module tb_prio_scan_unit;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [W-1:0]  in_a, in_b, in_mask;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_cnt;
  logic          out_zero;
  logic          out_last;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int data;
    int idx;
    int zero;
    int last;
  } beat_t;

  beat_t exp_q[$];

  prio_scan_unit #(.W(W), .IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_mode_i  (in_mode),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .in_mask_i  (in_mask),
    .abort_i    (abort),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_idx_o  (out_idx),
    .out_cnt_o  (out_cnt),
    .out_zero_o (out_zero),
    .out_last_o (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat list for one command, derived straight from the mode rules.
  task automatic build_expected(input logic [1:0] mode, input int a, input int b, input int mask);
    int    set_bits[$];
    beat_t bt;
    int    full;
    full = (1 << W) - 1;
    exp_q.delete();
    if (mode == 2'd0) begin
      bt.data = ((a & mask) | (b & ~mask)) & full;
      bt.idx = 0; bt.zero = 0; bt.last = 1;
      exp_q.push_back(bt);
    end else if (a == 0) begin
      bt.data = 0; bt.idx = 0; bt.zero = 1; bt.last = 1;
      exp_q.push_back(bt);
    end else begin
      for (int i = 0; i < W; i++) if ((a >> i) & 1) set_bits.push_back(i);
      if (mode == 2'd1) set_bits = '{set_bits[0]};
      if (mode == 2'd3) set_bits.reverse();
      foreach (set_bits[n]) begin
        bt.data = 1 << set_bits[n];
        bt.idx  = set_bits[n];
        bt.zero = 0;
        bt.last = (n == set_bits.size() - 1) ? 1 : 0;
        exp_q.push_back(bt);
      end
    end
  endtask

  // rdy_style: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  task automatic run_cmd(input logic [1:0] mode, input int a, input int b, input int mask,
                         input int rdy_style);
    int j, k, guard;
    logic rdy;
    check_eq("in_ready_before_cmd", in_ready, 1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a[W-1:0];
    in_b     = b[W-1:0];
    in_mask  = mask[W-1:0];
    tick();
    in_valid = 1'b0;
    // Scramble the operands so any late sampling of them would show up.
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_mask  = W'($urandom);
    in_mode  = 2'($urandom);
    build_expected(mode, a, b, mask);
    j = 0; k = 0; guard = 0;
    while (j < exp_q.size() && guard < 200) begin
      guard++;
      case (rdy_style)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      k++;
      out_ready = rdy;
      check_eq("out_valid", out_valid, 1);
      check_eq("in_ready_busy", in_ready, 0);
      check_eq("out_data", out_data, exp_q[j].data);
      check_eq("out_idx", out_idx, exp_q[j].idx);
      check_eq("out_cnt", out_cnt, j);
      check_eq("out_zero", out_zero, exp_q[j].zero);
      check_eq("out_last", out_last, exp_q[j].last);
      tick();
      if (rdy) j++;
    end
    out_ready = 1'b0;
    check_eq("beat_budget", j, exp_q.size());
    check_eq("out_valid_after", out_valid, 0);
    check_eq("in_ready_after", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_a      = '0;
    in_b      = '0;
    in_mask   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_cnt", out_cnt, 0);
    check_eq("rst_out_zero", out_zero, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_in_ready", in_ready, 1);
    tick();

    // Directed cases.
    run_cmd(2'd0, 'hF0, 'h0F, 'hCC, 0);
    run_cmd(2'd1, 'h28, 0, 0, 0);
    run_cmd(2'd1, 'h00, 0, 0, 0);
    run_cmd(2'd2, 'h91, 0, 0, 0);
    run_cmd(2'd3, 'h91, 0, 0, 0);
    run_cmd(2'd2, 'hFF, 0, 0, 1);
    run_cmd(2'd3, 'h00, 0, 0, 1);

    // Abort on the second beat of a scan, together with out_ready.
    in_valid = 1'b1; in_mode = 2'd2; in_a = 'h0F;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("abort_beat0", out_data, 'h01);
    tick();
    check_eq("abort_beat1", out_data, 'h02);
    check_eq("abort_beat1_cnt", out_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    run_cmd(2'd1, 'h02, 0, 0, 0);

    // Abort in IDLE discards a simultaneously offered command.
    in_valid = 1'b1; in_mode = 2'd0; in_a = 'h55; in_b = 'hAA; in_mask = 'hF0;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    check_eq("abort_accept_valid", out_valid, 0);
    check_eq("abort_accept_in_ready", in_ready, 1);

    // Asynchronous reset in the middle of a scan.
    in_valid = 1'b1; in_mode = 2'd2; in_a = 'hAA;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check_eq("pre_rst_beat2", out_data, 'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_data", out_data, 0);
    check_eq("arst_idx", out_idx, 0);
    check_eq("arst_cnt", out_cnt, 0);
    check_eq("arst_last", out_last, 0);
    check_eq("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_cmd(2'd3, 'h81, 0, 0, 0);

    // Randomized commands with mixed backpressure.
    for (int n = 0; n < 60; n++) begin
      int a;
      a = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      run_cmd(2'($urandom), a, int'($urandom_range(0, (1 << W) - 1)),
              int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
